// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame driver: FSM encoding, pixel layout,
// on-wire colour order, brightness scaling and default bit timing.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_SHIFT,
        ST_LATCH
    } state_t;

    typedef enum logic {
        ORDER_GRB,
        ORDER_RGB
    } color_order_t;

    localparam color_order_t COLOR_ORDER = ORDER_GRB;
    localparam int           PIX_W       = 24;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef struct packed {
        logic [31:0] t_bit;
        logic [31:0] t0h;
        logic [31:0] t1h;
        logic [31:0] t_rst;
    } timing_t;

    // 1.25 us bit, 0.36 us / 0.80 us high times, 300 us latch gap
    function automatic timing_t default_timing(input int unsigned clk_hz);
        timing_t     t;
        int unsigned mhz;
        mhz     = clk_hz / 1_000_000;
        t.t_bit = mhz * 125 / 100;
        t.t0h   = mhz * 36 / 100;
        t.t1h   = mhz * 80 / 100;
        t.t_rst = mhz * 300;
        return t;
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, br} + 16'd1);
        return prod[15:8];
    endfunction

    function automatic logic [PIX_W-1:0] to_wire(input pixel_t px, input logic [7:0] br);
        logic [PIX_W-1:0] w;
        case (COLOR_ORDER)
            ORDER_GRB: w = {scale(px.g, br), scale(px.r, br), scale(px.b, br)};
            default:   w = {scale(px.r, br), scale(px.g, br), scale(px.b, br)};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Serialises one 24-bit word MSB first as WS2812 pulses; the next word can be
// loaded on the word_done cycle for a gapless stream.
module ws2812_bit_tx
    import ws2812_pkg::*;
#(
    parameter int T_BIT = 62,
    parameter int T0H   = 18,
    parameter int T1H   = 40
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic [PIX_W-1:0] word,
    output logic             led_data,
    output logic             bit23_phase,
    output logic             word_done
);

    localparam int CW = $clog2(T_BIT);

    logic [CW-1:0]    cnt;
    logic [4:0]       bit_idx;
    logic [PIX_W-1:0] sr;
    logic             active;
    logic             last_bit;
    logic [CW-1:0]    hi_len;

    assign last_bit    = (bit_idx == 5'd23);
    assign hi_len      = sr[PIX_W-1] ? CW'(T1H) : CW'(T0H);
    assign led_data    = active && (cnt < hi_len);
    // one cycle early so the buffer read lands just as the current word ends
    assign bit23_phase = active && last_bit && (cnt == CW'(T_BIT - 2));
    assign word_done   = active && last_bit && (cnt == CW'(T_BIT - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            sr      <= '0;
            active  <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            bit_idx <= '0;
            sr      <= word;
            active  <= 1'b1;
        end else if (active) begin
            if (cnt == CW'(T_BIT - 1)) begin
                cnt <= '0;
                if (last_bit) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 5'd1;
                    sr      <= {sr[PIX_W-2:0], 1'b0};
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws2812_frame_drv.sv
// WS2812 chain driver: pixel buffer, per-pixel brightness scaling, frame FSM
// with a single pending-refresh slot.
//   state    | meaning
//   IDLE     | line low, waiting for start
//   PREFETCH | pixel 0 read returning, loaded into the shifter
//   SHIFT    | pixels streaming, next pixel fetched during bit 23
//   LATCH    | line held low for the reset gap, done on the last cycle
module ws2812_frame_drv
    import ws2812_pkg::*;
#(
    parameter int N_LED = 64,
    parameter int T_BIT = 62,
    parameter int T0H   = 18,
    parameter int T1H   = 40,
    parameter int T_RST = 15000,
    parameter int AW    = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_r,
    input  logic [7:0]    wr_g,
    input  logic [7:0]    wr_b,
    input  logic [7:0]    bright,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          led_data
);

    localparam int IW = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int LW = (T_RST > 1) ? $clog2(T_RST) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_LED - 1);

    state_t           state, state_nx;
    logic             pending, pending_nx;
    logic [IW-1:0]    pix_idx, pix_idx_nx;
    logic [LW-1:0]    lat_cnt, lat_cnt_nx;
    logic             rd_en;
    logic [IW-1:0]    rd_addr;
    pixel_t           mem [N_LED];
    pixel_t           rd_px;
    logic [7:0]       rd_bright;
    logic             tx_load;
    logic             bit23_phase;
    logic             word_done;

    // bright is captured with the read so each pixel is scaled with its own sample
    always_ff @(posedge sys_clk) begin
        if (wr_en && (32'(wr_addr) < N_LED))
            mem[wr_addr[IW-1:0]] <= {wr_r, wr_g, wr_b};
        if (rd_en) begin
            rd_px     <= mem[rd_addr];
            rd_bright <= bright;
        end
    end

    ws2812_bit_tx #(
        .T_BIT (T_BIT),
        .T0H   (T0H),
        .T1H   (T1H)
    ) u_bit_tx (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .load        (tx_load),
        .word        (to_wire(rd_px, rd_bright)),
        .led_data    (led_data),
        .bit23_phase (bit23_phase),
        .word_done   (word_done)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            pix_idx <= '0;
            lat_cnt <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            pix_idx <= pix_idx_nx;
            lat_cnt <= lat_cnt_nx;
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        pix_idx_nx = pix_idx;
        lat_cnt_nx = lat_cnt;
        rd_en      = 1'b0;
        rd_addr    = '0;
        tx_load    = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx   = ST_PREFETCH;
                    rd_en      = 1'b1;
                    pix_idx_nx = '0;
                end
            end
            ST_PREFETCH: begin
                tx_load  = 1'b1;
                state_nx = ST_SHIFT;
                if (start) pending_nx = 1'b1;
            end
            ST_SHIFT: begin
                if (start) pending_nx = 1'b1;
                if (bit23_phase && (pix_idx != LAST)) begin
                    rd_en   = 1'b1;
                    rd_addr = pix_idx + 1'b1;
                end
                if (word_done) begin
                    if (pix_idx == LAST) begin
                        state_nx   = ST_LATCH;
                        lat_cnt_nx = LW'(T_RST - 1);
                    end else begin
                        pix_idx_nx = pix_idx + 1'b1;
                        tx_load    = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (lat_cnt == '0) begin
                    done = 1'b1;
                    // a start arriving on the done cycle still counts as a pending request
                    if (pending || start) begin
                        state_nx   = ST_PREFETCH;
                        pending_nx = 1'b0;
                        rd_en      = 1'b1;
                        pix_idx_nx = '0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else begin
                    lat_cnt_nx = lat_cnt - 1'b1;
                    if (start) pending_nx = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ws2812_frame_drv.sv
// Bench for ws2812_frame_drv: frame-timeline model checked every cycle, plus
// hand-computed waveform points per scenario.
module tb_ws2812_frame_drv;

    localparam int N       = 2;
    localparam int TB      = 10;
    localparam int T0      = 3;
    localparam int T1      = 7;
    localparam int TR      = 20;
    localparam int AWB     = 2;
    localparam int PIX_CYC = 24 * TB;
    localparam int FRAME   = 1 + N * PIX_CYC + TR;
    localparam int DEPTH   = 16384;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic           wr_en   = 1'b0;
    logic [AWB-1:0] wr_addr = '0;
    logic [7:0]     wr_r = '0, wr_g = '0, wr_b = '0;
    logic [7:0]     bright = 8'hFF;
    logic           start = 1'b0;
    logic           busy, done, led_data;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    bit cap_led  [DEPTH];
    bit cap_busy [DEPTH];
    bit cap_done [DEPTH];

    ws2812_frame_drv #(
        .N_LED (N), .T_BIT (TB), .T0H (T0), .T1H (T1), .T_RST (TR), .AW (AWB)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_r     (wr_r),
        .wr_g     (wr_g),
        .wr_b     (wr_b),
        .bright   (bright),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .led_data (led_data)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // model: shadow buffer, frame launch cycle, pending flag, wire words snapshotted at read time
    logic [23:0] shadow [N];
    logic [23:0] m_pix  [N];
    bit          m_active;
    bit          m_pending;
    int          m_L;

    function automatic logic [23:0] wire_word(input logic [23:0] rgb, input int br);
        int r, g, b;
        r = (int'(rgb[23:16]) * (br + 1)) / 256;
        g = (int'(rgb[15:8])  * (br + 1)) / 256;
        b = (int'(rgb[7:0])   * (br + 1)) / 256;
        return {8'(g), 8'(r), 8'(b)};
    endfunction

    function automatic logic [2:0] model_out(input int c);
        int off, o, p, bi, ph;
        logic bv, led, dn;
        if (!m_active) return 3'b000;
        off = c - m_L;
        dn  = (off == FRAME - 1);
        led = 1'b0;
        if (off >= 1 && off <= N * PIX_CYC) begin
            o   = off - 1;
            p   = o / PIX_CYC;
            bi  = (o % PIX_CYC) / TB;
            ph  = o % TB;
            bv  = m_pix[p][23 - bi];
            led = (ph < (bv ? T1 : T0));
        end
        return {1'b1, dn, led};
    endfunction

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_active  <= 1'b0;
            m_pending <= 1'b0;
        end else begin
            if (m_active && cyc == m_L + FRAME - 1) begin
                if (m_pending || start) begin
                    m_L       <= cyc + 1;
                    m_pix[0]  <= wire_word(shadow[0], int'(bright));
                    m_pending <= 1'b0;
                end else begin
                    m_active <= 1'b0;
                end
            end else if (m_active) begin
                if (start) m_pending <= 1'b1;
                for (int p = 1; p < N; p++)
                    if (cyc == m_L + p * PIX_CYC - 1)
                        m_pix[p] <= wire_word(shadow[p], int'(bright));
            end else if (start) begin
                m_active <= 1'b1;
                m_L      <= cyc + 1;
                m_pix[0] <= wire_word(shadow[0], int'(bright));
            end
            if (wr_en && int'(wr_addr) < N)
                shadow[wr_addr[0]] <= {wr_r, wr_g, wr_b};
        end
    end

    always @(negedge sys_clk) begin
        if (cyc < DEPTH) begin
            cap_led[cyc]  <= led_data;
            cap_busy[cyc] <= busy;
            cap_done[cyc] <= done;
        end
        if (!sys_rst) begin
            checks++;
            if ({busy, done, led_data} !== model_out(cyc)) begin
                failures++;
                $display("FAIL cycle_model @%0d: busy/done/led got %b expected %b",
                         cyc, {busy, done, led_data}, model_out(cyc));
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        wr_en = 1'b1; wr_addr = AWB'(a); wr_r = r; wr_g = g; wr_b = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int count_led(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(cap_led[i]);
        return n;
    endfunction

    function automatic int count_done(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b; i++) n += int'(cap_done[i]);
        return n;
    endfunction

    int s, s2;

    initial begin
        chk("model_scale_c8_127", int'(wire_word(24'h00C800, 127)), 24'h640000);
        chk("model_order_grb",    int'(wire_word(24'hFF0081, 255)), 24'h00FF81);
        chk("model_bright0",      int'(wire_word(24'hFFFFFF, 0)),   0);

        tick(); tick(); tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_led",  int'(led_data), 0);
        chk("reset_done", int'(done), 0);
        sys_rst = 1'b0;
        tick();

        // single frame
        wr(0, 8'hFF, 8'h00, 8'h81);
        wr(1, 8'h00, 8'h00, 8'h00);
        bright = 8'hFF;
        pulse_start(s);
        run_to(s + FRAME + 4);
        chk("s1_busy_pre",   int'(cap_busy[s]), 0);
        chk("s1_busy_first", int'(cap_busy[s + 1]), 1);
        chk("s1_prefetch_low", int'(cap_led[s + 1]), 0);
        chk("s1_g0_hi",      int'(cap_led[s + 2]), 1);
        chk("s1_g0_hi_end",  int'(cap_led[s + 4]), 1);
        chk("s1_g0_lo",      int'(cap_led[s + 5]), 0);
        chk("s1_g_high_cnt", count_led(s + 2, s + 81), 8 * T0);
        chk("s1_r0_hi_end",  int'(cap_led[s + 88]), 1);
        chk("s1_r0_lo",      int'(cap_led[s + 89]), 0);
        chk("s1_b0_hi_end",  int'(cap_led[s + 168]), 1);
        chk("s1_b1_lo",      int'(cap_led[s + 175]), 0);
        chk("s1_b7_hi_end",  int'(cap_led[s + 238]), 1);
        chk("s1_b7_lo",      int'(cap_led[s + 239]), 0);
        chk("s1_px1_cnt",    count_led(s + 242, s + 481), 24 * T0);
        chk("s1_latch_low",  count_led(s + 482, s + 501), 0);
        chk("s1_no_early_done", count_done(s, s + 500), 0);
        chk("s1_done",       int'(cap_done[s + 501]), 1);
        chk("s1_busy_last",  int'(cap_busy[s + 501]), 1);
        chk("s1_busy_end",   int'(cap_busy[s + 502]), 0);

        // brightness
        wr(0, 8'hFF, 8'hC8, 8'h81);
        bright = 8'd127;
        pulse_start(s);
        run_to(s + FRAME + 4);
        chk("s2_g0_lo",  int'(cap_led[s + 5]), 0);
        chk("s2_g1_hi",  int'(cap_led[s + 18]), 1);
        chk("s2_g2_hi",  int'(cap_led[s + 28]), 1);
        chk("s2_g3_lo",  int'(cap_led[s + 35]), 0);
        chk("s2_g_cnt",  count_led(s + 2, s + 81), 3 * T1 + 5 * T0);
        chk("s2_r0_lo",  int'(cap_led[s + 85]), 0);
        bright = 8'd0;
        pulse_start(s);
        run_to(s + FRAME + 4);
        chk("s2_bright0_cnt", count_led(s + 2, s + 481), 48 * T0);
        bright = 8'hFF;

        // pending: one extra start mid-frame
        pulse_start(s);
        run_to(s + 100);
        pulse_start(s2);
        run_to(s + 2 * FRAME + 8);
        chk("s3_busy_gap",   int'(cap_busy[s + FRAME + 1]), 1);
        chk("s3_done_cnt",   count_done(s, s + 2 * FRAME + 6), 2);
        chk("s3_done2",      int'(cap_done[s + 2 * FRAME]), 1);
        chk("s3_busy_end",   int'(cap_busy[s + 2 * FRAME + 1]), 0);

        // pending: three extra starts merge into one
        pulse_start(s);
        run_to(s + 50);  pulse_start(s2);
        run_to(s + 100); pulse_start(s2);
        run_to(s + 150); pulse_start(s2);
        run_to(s + 2 * FRAME + 8);
        chk("s3b_done_cnt",  count_done(s, s + 2 * FRAME + 6), 2);
        chk("s3b_busy_end",  int'(cap_busy[s + 2 * FRAME + 1]), 0);

        // start on the done cycle
        pulse_start(s);
        run_to(s + FRAME);
        pulse_start(s2);
        run_to(s + 2 * FRAME + 8);
        chk("s3c_busy_gap",  int'(cap_busy[s + FRAME + 1]), 1);
        chk("s3c_done_cnt",  count_done(s, s + 2 * FRAME + 6), 2);

        // mid-frame writes
        wr(0, 8'h00, 8'h00, 8'h00);
        wr(1, 8'h00, 8'h00, 8'h00);
        pulse_start(s);
        run_to(s + 30);
        wr(1, 8'hFF, 8'hFF, 8'hFF);
        wr(0, 8'hFF, 8'hFF, 8'hFF);
        run_to(s + FRAME + 4);
        chk("s4_px0_old", count_led(s + 2, s + 241), 24 * T0);
        chk("s4_px1_new", count_led(s + 242, s + 481), 24 * T1);
        pulse_start(s);
        run_to(s + FRAME + 4);
        chk("s4_px0_next", count_led(s + 2, s + 241), 24 * T1);

        // reset during a bit high phase
        pulse_start(s);
        run_to(s + 4);
        chk("s5_led_before", int'(led_data), 1);
        sys_rst = 1'b1;
        #1;
        chk("s5_led_rst",  int'(led_data), 0);
        chk("s5_busy_rst", int'(busy), 0);
        chk("s5_done_rst", int'(done), 0);
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        wr(0, 8'hFF, 8'hFF, 8'hFF);
        wr(1, 8'h12, 8'h34, 8'h56);
        chk("s5_no_done", count_done(s, cyc - 1), 0);
        pulse_start(s);
        run_to(s + FRAME + 4);
        chk("s5_busy_first", int'(cap_busy[s + 1]), 1);
        chk("s5_px0_hi_end", int'(cap_led[s + 8]), 1);
        chk("s5_px0_lo",     int'(cap_led[s + 9]), 0);
        chk("s5_px1_g0_lo",  int'(cap_led[s + 245]), 0);
        chk("s5_px1_g2_hi",  int'(cap_led[s + 268]), 1);
        chk("s5_px1_cnt",    count_led(s + 242, s + 481), 9 * T1 + 15 * T0);

        // out-of-range writes
        wr(3, 8'h00, 8'h00, 8'h00);
        wr(2, 8'h00, 8'h00, 8'h00);
        pulse_start(s);
        run_to(s + FRAME + 4);
        chk("s6_px0_cnt",   count_led(s + 2, s + 241), 24 * T1);
        chk("s6_px1_g2_hi", int'(cap_led[s + 268]), 1);
        chk("s6_px1_cnt",   count_led(s + 242, s + 481), 9 * T1 + 15 * T0);
        chk("s6_done",      int'(cap_done[s + FRAME]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_drv.md
Name: ws2812_frame_drv

Overview:
- Parametrised WS2812 chain driver for the LED drawing path; owns an N_LED-pixel frame buffer, global brightness scaling and bit-level serialisation onto led_data.
- Upstream drawing and colour logic writes pixels through a simple write port, then requests a frame refresh with a start/busy/done handshake.
- Generalises the fixed cfg/ctrl pair: LED count, bit timing and latch time are parameters.
- Adds one pending-refresh slot and brightness scaling, which the fixed pair lacks.

Parameters:
- N_LED, 64, number of LEDs in the chain (1..256)
- T_BIT, 62, clock cycles per data bit (1.25 us at 50 MHz)
- T0H, 18, high cycles for a '0' bit; requires 0 < T0H < T1H < T_BIT
- T1H, 40, high cycles for a '1' bit
- T_RST, 15000, low cycles of the latch/reset gap after the last bit (300 us at 50 MHz)
- AW, $clog2(N_LED), pixel address width (minimum 1)

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  pixel write strobe
- wr_addr  in  AW  pixel index; writes with wr_addr >= N_LED are ignored
- wr_r / wr_g / wr_b  in  8 each  pixel colour
- bright  in  8  global brightness; sampled per pixel at load
- start  in  1  frame refresh request (level-sampled each cycle)
- busy  out  1  high from frame launch until end of latch gap
- done  out  1  one-cycle pulse at end of latch gap
- led_data  out  1  serial WS2812 line

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: led_data=0, busy=0, done=0, pending=0, FSM=IDLE. Buffer contents are undefined after reset; the bench writes before the first frame.
- Buffer: N_LED x 24 bits, stored as {r,g,b}, synchronous write, synchronous read with 1-cycle latency. Writes are accepted in any state.
- Scaling: out_c = (c * (bright + 1)) >> 8, 16-bit product truncated to 8 bits.
  - bright=255 gives identity.
  - bright=0 gives c>>8, i.e. 0.
- Wire order per pixel: G[7:0], then R[7:0], then B[7:0], MSB first.
- FSM states: IDLE, PREFETCH, SHIFT, LATCH.
- IDLE:
  - start=1 at cycle k: busy=1 at k+1; buffer read of addr 0 issued; go to PREFETCH.
- PREFETCH (1 cycle):
  - Latch the scaled pixel 0 into the shift register.
  - SHIFT begins at k+2, and led_data rises at k+2.
- SHIFT, per bit:
  - Bit counter runs 0..T_BIT-1.
  - led_data = 1 while counter < (bit ? T1H : T0H), else 0.
  - During bit 23 of pixel p (p < N_LED-1), read of p+1 is issued, so the next pixel follows with no gap cycle.
  - Pixel counter wraps from N_LED-1 to LATCH after bit 23 completes.
- LATCH:
  - led_data=0 for exactly T_RST cycles.
  - On the last cycle, done=1 for that cycle only.
  - Next cycle: if pending=1, clear pending and re-enter PREFETCH (busy stays 1, addr 0 read); otherwise go to IDLE with busy=0.
- Frame busy length: 1 + N_LED*24*T_BIT + T_RST cycles.
- start while busy sets pending=1. Multiple requests merge into one, giving at most one extra frame.
- start held continuously causes back-to-back frames.
- A write to pixel p takes effect in the current frame only if it lands at least 1 cycle before p's read is issued. Otherwise it appears in the next frame. There is no tearing within a pixel, because the shift register holds a snapshot.
- bright is sampled at each pixel's read, so mid-frame changes affect later pixels only.
- Reset mid-frame: led_data drops to 0 immediately (asynchronous); FSM goes to IDLE; pending is cleared; done is not pulsed.
- Simultaneous start and done cycle: start is treated as busy, so pending=1 and the next frame follows immediately.

Decomposition:
- Package ws2812_pkg holds:
  - FSM state encoding
  - colour-order constant (GRB)
  - a 24-bit pixel struct/width constant
  - a default-timing function deriving T_BIT/T0H/T1H/T_RST from CLK_HZ
- One sub-module, ws2812_bit_tx: takes a 24-bit word and a load strobe, and outputs led_data plus a bit23_phase/word_done strobe. It owns the bit/timing counters.
- The top holds the buffer, scaler, pixel counter, pending flag and FSM.

Test Plan:
- Bench parameters for all scenarios: N_LED=2, T_BIT=10, T0H=3, T1H=7, T_RST=20.
- Single frame:
  - Stimulus: write px0={r=FF,g=00,b=81}, px1=000000; bright=255; start pulse at cycle 0.
  - Required: busy at 1–501; first 8 bits all '0' (3 high, 7 low each); R bits all '1' (7 high); B pattern 10000001; px1 all '0'; done pulse at cycle 501; led_data low for 20 cycles before it.
- Brightness:
  - Stimulus: px0 g=C8, bright=127.
  - Required: G sent as 64 (=C8*128>>8); with bright=0 every bit is '0'.
- Pending:
  - Stimulus: second start at cycle 100 of a frame.
  - Required: exactly one extra frame, PREFETCH starting the cycle after done, busy never dropping. Three extra starts still give exactly one extra frame.
- Mid-frame write:
  - Stimulus: during px0 shifting, write px1=FFFFFF; also write px0=FFFFFF.
  - Required: current frame sends px1 all '1' and px0 unchanged; next frame sends px0 all '1'.
- Reset:
  - Stimulus: assert sys_rst in the middle of a bit high phase.
  - Required: led_data=0 and busy=0 in the same cycle, no done pulse; a start after release begins a clean frame at pixel 0.
- Address bound:
  - Stimulus: write to wr_addr=3 with N_LED=2.
  - Required: buffer unchanged; frame output identical to the previous frame.
